// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - machine-mode interrupt pending, gating and fixed-priority arbitration
//
// Purpose:
//   Tracks per-source pending state (edge-latched or level), gates it with
//   mie / mstatus.MIE / privilege, picks the lowest-index eligible source and
//   holds a request toward fetch until it is acknowledged or loses eligibility.
//
// Ports:
//   clk, reset     core clock, synchronous active-high reset
//   irq_i          raw interrupt lines, one per source
//   ie_i           per-source enable (mie)
//   mstatus_mie    global machine interrupt enable
//   priv           current privilege mode (2'b11 = M)
//   boundary_ok    fetch is at an instruction boundary that can take a trap
//   clr_i          software clear of edge-pending bits (mip write)
//   take_ack       pipeline accepted the requested trap this cycle
//   req_valid      interrupt trap requested (held until ack or cancel)
//   req_cause      mcause value {1, zero-extended cause code}
//   req_idx        index of the requesting source
//   pend_o         pending vector for the mip view
module irq_arbiter #(
  parameter int                  NSRC        = 3,
  parameter logic [NSRC-1:0]     EDGE_MASK   = {NSRC{1'b1}},
  parameter logic [6*NSRC-1:0]   CAUSE_CODES = {6'd11, 6'd3, 6'd7},
  parameter int                  XLEN        = 64,
  localparam int                 IDXW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_i,
  input  logic [NSRC-1:0] ie_i,
  input  logic            mstatus_mie,
  input  logic [1:0]      priv,
  input  logic            boundary_ok,
  input  logic [NSRC-1:0] clr_i,
  input  logic            take_ack,
  output logic            req_valid,
  output logic [XLEN-1:0] req_cause,
  output logic [IDXW-1:0] req_idx,
  output logic [NSRC-1:0] pend_o
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] ack_clr;
  logic            global_en;
  logic            any_elig;
  logic [IDXW-1:0] win_idx;
  logic [5:0]      win_code;

  // Lower privilege modes always take machine interrupts; M-mode needs MIE.
  assign global_en = mstatus_mie | (priv != 2'b11);
  assign elig      = pend & ie_i & {NSRC{global_en}};
  assign pend_o    = pend;

  // Fixed priority: scan from the top so the lowest eligible index wins.
  always_comb begin
    any_elig = 1'b0;
    win_idx  = '0;
    win_code = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        any_elig = 1'b1;
        win_idx  = IDXW'(i);
        win_code = CAUSE_CODES[6*i +: 6];
      end
    end
  end

  // Edge sources: a new rising edge beats a simultaneous ack/clear so the
  // fresh event is not lost. Level sources simply follow the line.
  always_comb begin
    pend_nxt = '0;
    ack_clr  = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_clr[i] = (state == REQ) && take_ack && (req_idx == IDXW'(i));
      if (EDGE_MASK[i]) begin
        pend_nxt[i] = (irq_i[i] & ~irq_q[i]) | (pend[i] & ~(clr_i[i] | ack_clr[i]));
      end else begin
        pend_nxt[i] = irq_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      irq_q     <= '0;
      pend      <= '0;
      req_valid <= 1'b0;
      req_cause <= '0;
      req_idx   <= '0;
    end else begin
      irq_q <= irq_i;
      pend  <= pend_nxt;
      case (state)
        IDLE: begin
          if (any_elig && boundary_ok) begin
            state     <= REQ;
            req_valid <= 1'b1;
            req_idx   <= win_idx;
            req_cause <= {1'b1, {(XLEN-7){1'b0}}, win_code};
          end
        end
        REQ: begin
          // Cause and index stay frozen; ack has priority over a cancel.
          if (take_ack) begin
            state     <= IDLE;
            req_valid <= 1'b0;
          end else if (!elig[req_idx]) begin
            state     <= IDLE;
            req_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
